// File: rtl/acc_pkg.sv
// Shared opcode constants for the AC accumulator and the control unit.
package acc_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD  = 3'd0;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'd1;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD   = 3'd3;
  localparam logic [OP_W-1:0] OP_INC   = 3'd4;
  localparam logic [OP_W-1:0] OP_DEC   = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL   = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR   = 3'd7;

endpackage

// File: rtl/acc_alu.sv
// Combinational next-state logic for the accumulator: one result and one
// carry/borrow/shift-out bit per opcode.
module acc_alu
  import acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             next_carry_o
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;

  // Bit WIDTH of each extended result is the carry-out, or the borrow for DEC.
  assign w_sum = {1'b0, q_i} + {1'b0, d_i};
  assign w_inc = {1'b0, q_i} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec = {1'b0, q_i} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    next_q_o     = q_i;
    next_carry_o = carry_i;
    case (op_i)
      OP_HOLD: begin
        next_q_o     = q_i;
        next_carry_o = carry_i;
      end
      OP_LOAD: begin
        next_q_o     = d_i;
        next_carry_o = 1'b0;
      end
      OP_CLEAR: begin
        next_q_o     = '0;
        next_carry_o = 1'b0;
      end
      OP_ADD:  {next_carry_o, next_q_o} = w_sum;
      OP_INC:  {next_carry_o, next_q_o} = w_inc;
      OP_DEC:  {next_carry_o, next_q_o} = w_dec;
      OP_SHL: begin
        next_carry_o = q_i[WIDTH-1];
        next_q_o     = {q_i[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        next_carry_o = q_i[0];
        next_q_o     = {1'b0, q_i[WIDTH-1:1]};
      end
      default: begin
        next_q_o     = q_i;
        next_carry_o = carry_i;
      end
    endcase
  end

endmodule

// File: rtl/acc_reg.sv
// Accumulator register: state flops with reset/enable priority around acc_alu,
// plus zero and negative status taken straight from the stored value.
module acc_reg
  import acc_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             neg_o
);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic [WIDTH-1:0] w_next_q;
  logic             w_next_carry;

  acc_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .q_i         (r_q),
    .carry_i     (r_carry),
    .d_i         (d_i),
    .op_i        (op_i),
    .next_q_o    (w_next_q),
    .next_carry_o(w_next_carry)
  );

  // Reset beats enable; a disabled edge freezes both value and carry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q     <= RESET_VAL;
      r_carry <= 1'b0;
    end else if (en_i) begin
      r_q     <= w_next_q;
      r_carry <= w_next_carry;
    end
  end

  assign q_o     = r_q;
  assign carry_o = r_carry;
  assign zero_o  = (r_q == '0);
  assign neg_o   = r_q[WIDTH-1];

endmodule

// File: doc/acc_reg.md
# acc_reg

Parametrised accumulator register for the AC datapath, replacing the fixed 8-bit write-enable register. It holds a WIDTH-bit value. On each enabled clock it performs one operation chosen by an opcode: load, clear, add, increment, decrement, or logical shift. It keeps a registered carry/borrow flag and provides zero and negative status for the control unit.

## Interface
Parameters:
- WIDTH, 8: data width in bits; legal range 2 to 32.
- RESET_VAL, 0: value loaded into q_o on reset; WIDTH bits.

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- en_i  input  1  operation enable; when 0 the register holds, whatever op_i is.
- op_i  input  3  operation select; encoding is given under Operation.
- d_i  input  WIDTH  operand for LOAD and ADD.
- q_o  output  WIDTH  accumulator contents, registered.
- carry_o  output  1  carry/borrow/shifted-out bit, registered.
- zero_o  output  1  1 when q_o == 0; combinational from q_o.
- neg_o  output  1  equal to q_o[WIDTH-1]; combinational from q_o.

## Operation
- Opcodes:
  - 0 HOLD
  - 1 LOAD
  - 2 CLEAR
  - 3 ADD
  - 4 INC
  - 5 DEC
  - 6 SHL
  - 7 SHR
- HOLD: q and carry unchanged.
- LOAD: q <= d_i; carry <= 0.
- CLEAR: q <= 0; carry <= 0.
- ADD: {carry, q} <= q + d_i, computed at WIDTH+1 bits. Result wraps modulo 2^WIDTH; carry is the carry-out.
- INC: q <= q + 1. carry <= 1 only when the old q was all ones; the result then wraps to 0.
- DEC: q <= q - 1. carry (borrow) <= 1 only when the old q was 0; the result then wraps to all ones.
- SHL: carry <= q[WIDTH-1]; q <= {q[WIDTH-2:0], 0}.
- SHR (logical): carry <= q[0]; q <= {0, q[WIDTH-1:1]}.
- d_i is ignored for every opcode except LOAD and ADD.
- Priority, highest first:
  - rst_i: q <= RESET_VAL, carry <= 0.
  - en_i = 0: hold.
  - op_i decode.
- The opcode list is exhaustive; no illegal opcodes exist.
- All arithmetic is unsigned and performed at exactly WIDTH bits, plus 1 bit for carry. No saturation.

## Timing
- Reset values: q_o = RESET_VAL, carry_o = 0. zero_o and neg_o follow from RESET_VAL; with the default, zero_o = 1 and neg_o = 0.
- Latency is 1 cycle. Inputs sampled at edge N appear on q_o/carry_o after edge N and stay stable until the next enabled edge.
- zero_o and neg_o change in the same cycle as q_o; there is no extra register stage.
- Back-to-back operations are allowed on every cycle. Each one uses the q value produced by the previous edge.
- rst_i asserted in the same cycle as en_i=1 with any opcode: reset wins and the operation is discarded.
- Reset deasserted: the first operation is taken at the first edge where rst_i = 0.
- en_i deasserted mid-sequence: q and carry freeze exactly, including carry from the last operation.

## Structure
- Shared package acc_pkg holds:
  - the opcode localparams OP_HOLD … OP_SHR, 3 bits wide;
  - OP_W = 3.
  - The control unit uses the same constants.
- One sub-module is natural: acc_alu, purely combinational. It takes q, d, and op and returns next_q and next_carry.
- acc_reg itself contains only the state flops, the reset/enable priority, and the flag assigns.
- No other hierarchy.

## Test plan
All scenarios use WIDTH=8, RESET_VAL=0.
- Reset and load:
  - rst_i=1 for one edge: q=0x00, carry=0, zero=1.
  - Then LOAD 0xCC: q=0xCC, neg=1, zero=0.
- Enable gating:
  - en_i=0, op=LOAD, d=0xFF for 3 edges: q stays 0xCC.
  - Then en_i=1, op=HOLD: q still 0xCC.
- Add with carry:
  - LOAD 0xF0, then ADD 0x20: q=0x10, carry=1.
  - Then ADD 0x01: q=0x11, carry=0.
- Wrap-around:
  - LOAD 0xFF, INC: q=0x00, carry=1, zero=1.
  - Then DEC: q=0xFF, carry=1.
  - Then DEC: q=0xFE, carry=0.
- Shifts:
  - LOAD 0x81, SHL: q=0x02, carry=1.
  - SHR: q=0x01, carry=0.
  - SHR: q=0x00, carry=1, zero=1.
- Reset priority and RESET_VAL:
  - Second instance with RESET_VAL=0x5A.
  - rst_i=1 together with en_i=1, op=LOAD, d=0x33: q=0x5A, carry=0.
  - Next edge with rst_i=0: q=0x33.
